// File: rtl/ps2_atom_keyboard.sv
// PS/2 keyboard receiver and decoder that maintains the Atom 10x6 key matrix and modifier lines.
// Optional build macro PS2_PARITY_CHECK_EN: discard frames that fail odd parity.
module ps2_atom_keyboard #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] row,
    output logic [5:0] keyout,
    output logic       shift_n,
    output logic       ctrl_n,
    output logic       rept_n,
    output logic       break_n,
    output logic       frame_err
);
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_SKIP} state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic [FW-1:0] fcnt;
    logic          fclk, fclk_d, fall;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [TW-1:0] tmo;
    logic          byte_valid, par_bad;
    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic          key_wr, key_make, key_ext;
    logic          map_hit;
    logic [3:0]    map_row;
    logic [2:0]    map_col;
    logic [5:0]    mod_hit;
    logic [5:0]    mods;
    logic [9:0][5:0] matrix;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            fcnt    <= '0;
            fclk    <= 1'b1;
            fclk_d  <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            fclk_d  <= fclk;
            if (clk_s2 == fclk) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                fclk <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fall = fclk_d & ~fclk;

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            par_bit <= 1'b0;
        else if (fall && bit_cnt == 4'd9)
            par_bit <= data_s2;
    end
    assign par_bad = ~(^{shreg, par_bit});
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tmo        <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo <= TW'(TIMEOUT);
                case (bit_cnt)
                    4'd0: begin
                        if (data_s2) frame_err <= 1'b1;
                        else         bit_cnt   <= 4'd1;
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        shreg   <= {data_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    4'd9: bit_cnt <= 4'd10;
                    default: begin
                        bit_cnt <= '0;
                        if (!data_s2 || par_bad) frame_err  <= 1'b1;
                        else                     byte_valid <= 1'b1;
                    end
                endcase
            end else if (bit_cnt != '0) begin
                if (tmo <= TW'(1)) begin
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                end else begin
                    tmo <= tmo - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        key_wr   = 1'b0;
        key_make = 1'b0;
        key_ext  = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (shreg == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (shreg == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (shreg == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else if (!(shreg inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin
                        key_wr   = 1'b1;
                        key_make = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (shreg == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        key_wr   = 1'b1;
                        key_make = 1'b1;
                        key_ext  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    key_wr  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    key_wr  = 1'b1;
                    key_ext = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // mod_hit bits: 0 lshift, 1 rshift, 2 lctrl, 3 rctrl, 4 lalt (REPT), 5 F12 (BREAK)
    always_comb begin
        map_hit = 1'b0;
        map_row = '0;
        map_col = '0;
        mod_hit = '0;
        case ({key_ext, shreg})
            9'h01C: begin map_hit = 1'b1; map_row = 4'd3; map_col = 3'd4; end
            9'h029: begin map_hit = 1'b1; map_row = 4'd9; map_col = 3'd0; end
            9'h016: begin map_hit = 1'b1; map_row = 4'd8; map_col = 3'd2; end
            9'h175: begin map_hit = 1'b1; map_row = 4'd5; map_col = 3'd1; end
            9'h012: mod_hit = 6'b000001;
            9'h059: mod_hit = 6'b000010;
            9'h014: mod_hit = 6'b000100;
            9'h114: mod_hit = 6'b001000;
            9'h011: mod_hit = 6'b010000;
            9'h007: mod_hit = 6'b100000;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix <= '0;
            mods   <= '0;
        end else if (key_wr) begin
            if (map_hit) matrix[map_row][map_col] <= key_make;
            mods <= key_make ? (mods | mod_hit) : (mods & ~mod_hit);
        end
    end

    always_comb begin
        keyout = '1;
        if (row <= 4'd9) keyout = ~matrix[row];
    end

    assign shift_n = ~(mods[0] | mods[1]);
    assign ctrl_n  = ~(mods[2] | mods[3]);
    assign rept_n  = ~mods[4];
    assign break_n = ~mods[5];

endmodule

// File: tb/tb_ps2_atom_keyboard.sv
// Bench for ps2_atom_keyboard: drives PS/2 frames and compares the outputs to a key-state model.
// Honours PS2_PARITY_CHECK_EN the same way the design does.
module tb_ps2_atom_keyboard;
    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 300;
    localparam int unsigned HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] row = 4'd0;
    logic [5:0] keyout;
    logic       shift_n, ctrl_n, rept_n, break_n, frame_err;

    int checks = 0;
    int errors = 0;
    int dut_err_cnt = 0;
    int exp_err_cnt = 0;
    bit settled = 1'b0;

    // model state: pressed keys per row/column, held modifiers, pending prefixes
    bit [5:0] m_mat [16];
    bit m_lshift, m_rshift, m_lctrl, m_rctrl, m_alt, m_f12;
    bit pend_ext, pend_brk;
    int skip_left;

    always #5 clk = ~clk;

    ps2_atom_keyboard #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .row(row), .keyout(keyout), .shift_n(shift_n), .ctrl_n(ctrl_n),
        .rept_n(rept_n), .break_n(break_n), .frame_err(frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_mat[i] = '0;
        {m_lshift, m_rshift, m_lctrl, m_rctrl, m_alt, m_f12} = '0;
        pend_ext = 0; pend_brk = 0; skip_left = 0;
    endtask

    task automatic model_key(input bit ext, input logic [7:0] code, input bit make);
        case ({ext, code})
            9'h01C: m_mat[3][4] = make;
            9'h029: m_mat[9][0] = make;
            9'h016: m_mat[8][2] = make;
            9'h175: m_mat[5][1] = make;
            9'h012: m_lshift = make;
            9'h059: m_rshift = make;
            9'h014: m_lctrl = make;
            9'h114: m_rctrl = make;
            9'h011: m_alt = make;
            9'h007: m_f12 = make;
            default: ;
        endcase
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (skip_left > 0) begin
            skip_left--;
        end else if (pend_brk) begin
            model_key(pend_ext, b, 1'b0);
            pend_ext = 0; pend_brk = 0;
        end else if (pend_ext) begin
            if (b == 8'hF0) pend_brk = 1;
            else begin model_key(1'b1, b, 1'b1); pend_ext = 0; end
        end else if (b == 8'hE0) pend_ext = 1;
        else if (b == 8'hF0) pend_brk = 1;
        else if (b == 8'hE1) skip_left = 7;
        else if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE})) model_key(1'b0, b, 1'b1);
    endtask

    always @(negedge clk) begin
        if (frame_err) dut_err_cnt++;
        if (settled && reset_n) begin
            check("keyout", {26'd0, keyout}, {26'd0, ~m_mat[row]});
            check("shift_n", {31'd0, shift_n}, {31'd0, ~(m_lshift | m_rshift)});
            check("ctrl_n", {31'd0, ctrl_n}, {31'd0, ~(m_lctrl | m_rctrl)});
            check("rept_n", {31'd0, rept_n}, {31'd0, ~m_alt});
            check("break_n", {31'd0, break_n}, {31'd0, ~m_f12});
            check("frame_err_count", dut_err_cnt, exp_err_cnt);
        end
    end

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int unsigned nbits);
        logic [10:0] f;
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        f = {~bad_stop, p, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic sweep_rows();
        for (int r = 0; r < 16; r++) begin
            row = 4'(r);
            tick(1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        settled = 1'b0;
        send_bits(b, bad_par, bad_stop, 11);
        tick(40);
        if (bad_stop || (bad_par && PAR_EN)) exp_err_cnt++;
        else model_byte(b);
        settled = 1'b1;
        sweep_rows();
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0);
    endtask

    task automatic peek_row(input logic [3:0] r, input logic [5:0] exp, input string name);
        row = r;
        tick(1);
        check(name, {26'd0, keyout}, {26'd0, exp});
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_clear();
        tick(3);
        check("reset_keyout", {26'd0, keyout}, 32'h3F);
        check("reset_shift_n", {31'd0, shift_n}, 32'd1);
        check("reset_ctrl_n", {31'd0, ctrl_n}, 32'd1);
        check("reset_rept_n", {31'd0, rept_n}, 32'd1);
        check("reset_break_n", {31'd0, break_n}, 32'd1);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        tick(5);
        settled = 1'b1;

        send(8'h1C);
        peek_row(4'd3, 6'b101111, "A_make");
        send(8'hF0); send(8'h1C);
        peek_row(4'd3, 6'b111111, "A_break");
        send(8'h1C); send(8'h1C);
        peek_row(4'd3, 6'b101111, "A_typematic");
        send(8'hF0); send(8'h1C);

        send(8'hE0); send(8'h75);
        peek_row(4'd5, 6'b111101, "up_make");
        send(8'h75);
        peek_row(4'd5, 6'b111101, "kp8_unmapped");
        send(8'hE0); send(8'hF0); send(8'h75);
        peek_row(4'd5, 6'b111111, "up_break");

        send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
        check("shift_both_then_one", {31'd0, shift_n}, 32'd0);
        send(8'hF0); send(8'h59);
        check("shift_released", {31'd0, shift_n}, 32'd1);
        send(8'h07);
        check("f12_break_n", {31'd0, break_n}, 32'd0);
        send(8'h11);
        check("lalt_rept_n", {31'd0, rept_n}, 32'd0);
        send(8'hF0); send(8'h11); send(8'hE0); send(8'h11);
        check("ralt_unmapped", {31'd0, rept_n}, 32'd1);

        send_byte(8'h1C, 1'b1, 1'b0);
        peek_row(4'd3, PAR_EN ? 6'b111111 : 6'b101111, "bad_parity_row3");
        check("bad_parity_errs", dut_err_cnt, PAR_EN ? 32'd1 : 32'd0);
        send(8'hF0); send(8'h1C);

        send_byte(8'h29, 1'b0, 1'b1);
        peek_row(4'd9, 6'b111111, "bad_stop_row9");

        settled = 1'b0;
        send_bits(8'h29, 1'b0, 1'b0, 5);
        tick(TMO + 10);
        exp_err_cnt++;
        settled = 1'b1;
        check("timeout_errs", dut_err_cnt, PAR_EN ? 32'd3 : 32'd2);
        sweep_rows();
        send(8'h29);
        peek_row(4'd9, 6'b111110, "space_after_timeout");

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h16);
        peek_row(4'd8, 6'b111011, "one_after_pause");
        check("pause_ctrl_n", {31'd0, ctrl_n}, 32'd1);

        settled = 1'b0;
        send_bits(8'h1C, 1'b0, 1'b0, 3);
        reset_n = 1'b0;
        model_clear();
        tick(3);
        peek_row(4'd8, 6'b111111, "midreset_row8");
        peek_row(4'd9, 6'b111111, "midreset_row9");
        check("midreset_break_n", {31'd0, break_n}, 32'd1);
        check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
        reset_n = 1'b1;
        tick(5);
        settled = 1'b1;
        sweep_rows();
        send(8'h29);
        peek_row(4'd9, 6'b111110, "space_after_reset");
        check("final_errs", dut_err_cnt, exp_err_cnt);

        settled = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
